// File: rtl/fifo_pkg.sv
// Shared defaults and types for the fifo block family.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 8;
    localparam int RD_BUF_DEPTH       = 2;

    typedef logic [1:0] occ_t;

    function automatic occ_t pending_f(input occ_t occ, input logic inflight);
        return occ + occ_t'(inflight);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry ordered output buffer for the FIFO read controller.
// Entry 0 is the head; vacated entries are zeroed so the head reads 0 when empty.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output occ_t             occ_o,
    output logic [WIDTH-1:0] head_o
);

    occ_t             occ_r;
    occ_t             occ_s;
    logic [WIDTH-1:0] ent0_r;
    logic [WIDTH-1:0] ent1_r;
    logic [WIDTH-1:0] ent0_s;
    logic [WIDTH-1:0] ent1_s;
    logic             pop_s;

    // Next-state of the ordered store; clear beats a same-cycle push.
    always_comb begin
        occ_s  = occ_r;
        ent0_s = ent0_r;
        ent1_s = ent1_r;
        pop_s  = pop_i & (occ_r != 2'd0);
        if (clear_i) begin
            occ_s  = 2'd0;
            ent0_s = {WIDTH{1'b0}};
            ent1_s = {WIDTH{1'b0}};
        end else begin
            case ({push_i, pop_s})
                2'b10: begin
                    case (occ_r)
                        2'd0: begin
                            ent0_s = push_data_i;
                            occ_s  = 2'd1;
                        end
                        2'd1: begin
                            ent1_s = push_data_i;
                            occ_s  = 2'd2;
                        end
                        default: begin
                        end
                    endcase
                end
                2'b01: begin
                    case (occ_r)
                        2'd1: begin
                            ent0_s = {WIDTH{1'b0}};
                            occ_s  = 2'd0;
                        end
                        2'd2: begin
                            ent0_s = ent1_r;
                            ent1_s = {WIDTH{1'b0}};
                            occ_s  = 2'd1;
                        end
                        default: begin
                        end
                    endcase
                end
                2'b11: begin
                    case (occ_r)
                        2'd1: ent0_s = push_data_i;
                        2'd2: begin
                            ent0_s = ent1_r;
                            ent1_s = push_data_i;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_r  <= 2'd0;
            ent0_r <= {WIDTH{1'b0}};
            ent1_r <= {WIDTH{1'b0}};
        end else begin
            occ_r  <= occ_s;
            ent0_r <= ent0_s;
            ent1_r <= ent1_s;
        end
    end

    assign occ_o  = occ_r;
    assign head_o = ent0_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the fifo block: issues read strobes, absorbs the
// one-cycle read latency and presents entries on valid/ready. FIFO_RD_STATS_EN adds counters.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEFAULT,
    parameter int BUF_DEPTH = RD_BUF_DEPTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_rd_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]      pop_count_o,
    output logic [31:0]      stall_count_o
`endif
);

    localparam occ_t FULL_OCC = occ_t'(BUF_DEPTH);

    occ_t occ_s;
    occ_t pending_s;
    logic inflight_r;
    logic drop_r;
    logic pop_s;
    logic rd_s;
    logic capture_s;

    fifo_rd_skid_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (flush_i),
        .push_i     (capture_s),
        .push_data_i(fifo_data_i),
        .pop_i      (pop_s),
        .occ_o      (occ_s),
        .head_o     (data_o)
    );

    assign valid_o   = (occ_s != 2'd0);
    assign capture_s = inflight_r & ~drop_r;
    assign fifo_rd_o = rd_s;

    // A strobe may refill the slot a same-cycle pop frees, so a full pipe still streams.
    always_comb begin
        pop_s     = valid_o & ready_i;
        pending_s = pending_f(occ_s, inflight_r);
        if (reset_i || flush_i || fifo_empty_i) begin
            rd_s = 1'b0;
        end else if (pending_s < FULL_OCC) begin
            rd_s = 1'b1;
        end else if ((pending_s == FULL_OCC) && pop_s) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
    end

    // In-flight tracking; drop marks a read whose data a flush has orphaned.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inflight_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            inflight_r <= rd_s;
            drop_r     <= flush_i & inflight_r;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] pop_cnt_r;
    logic [31:0] stall_cnt_r;

    // Handshake and backpressure statistics, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pop_cnt_r   <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (pop_s) begin
                pop_cnt_r <= pop_cnt_r + 32'd1;
            end
            if (valid_o && !ready_i) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign pop_count_o   = pop_cnt_r;
    assign stall_count_o = stall_cnt_r;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the team's `fifo` block: drives the FIFO read strobe and absorbs its registered, one-cycle read latency.
- Presents popped entries downstream on a valid/ready interface.
- Holds a 2-entry output buffer, so full throughput is 1 entry/cycle while ready_i stays high.
- Sits between instruction/result FIFOs and their consumers (dispatch, issue, commit); flush_i discards everything queued in the controller on a pipeline squash.

Parameters:
- WIDTH, 8, entry width; must match the connected FIFO's WIDTH.
- BUF_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  synchronous, active-high reset
- flush_i  input  1  discard buffered and in-flight entries
- fifo_empty_i  input  1  FIFO empty flag
- fifo_data_i  input  WIDTH  FIFO registered read data
- fifo_rd_o  output  1  FIFO read strobe, combinational
- valid_o  output  1  data_o holds a valid entry
- data_o  output  WIDTH  head entry of output buffer
- ready_i  input  1  consumer accepts data_o this cycle

Behaviour:
- Reset (reset_i=1 at edge): occupancy=0, inflight=0, drop=0, valid_o=0, data_o=0. The read strobe is forced low while reset_i=1, including reset asserted mid-operation. Reset overrides flush_i.
- pop = valid_o & ready_i. valid_o = (occupancy != 0).
- pending = occupancy + inflight, range 0..2.
- fifo_rd_o = !fifo_empty_i & !flush_i & !reset_i & (pending < 2 | (pending == 2 & pop)).
- inflight is set next cycle when fifo_rd_o=1; it is cleared otherwise.
- Capture: in the cycle after a strobe (inflight=1, drop=0), fifo_data_i is written to the buffer tail.
  - Capture and pop in the same cycle: occupancy is unchanged and the head advances.
- Read latency: data returned by the FIFO reaches data_o on the edge after capture. For an empty controller, valid_o rises 2 cycles after fifo_rd_o.
- Ordering: strict FIFO order; head is entry 0. On pop with occupancy 2, entry 1 moves to entry 0.
- data_o is 0 when valid_o=0. This is deterministic; no stale data is shown.
- Flush (flush_i=1):
  - occupancy := 0 and valid_o drops next cycle.
  - No strobe is issued that cycle.
  - If inflight=1, drop := 1 so the returning data is ignored; drop self-clears after one cycle.
  - pop in the flush cycle is still a legal handshake and the consumer may take data_o.
- Stall: with ready_i=0 and occupancy 2, the strobe stays low and data_o/valid_o hold stable (AXI-style: valid never retracts without flush/reset).
- FIFO's own zero output on non-read cycles is never captured, because capture is gated by inflight.
- Overflow is impossible by construction: pending never exceeds 2.

Optional Feature:
- FIFO_RD_STATS_EN defined: adds two outputs.
  - pop_count_o [31:0]: increments on each pop.
  - stall_count_o [31:0]: increments on each cycle with valid_o=1 and ready_i=0.
  - Both are zeroed by reset (not by flush) and wrap at 2^32.
- FIFO_RD_STATS_EN undefined: neither port nor any counter logic exists.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_WIDTH_DEFAULT = 8
  - RD_BUF_DEPTH = 2
  - the occupancy type (2-bit)
- One sub-module, fifo_rd_skid_buf: the 2-entry ordered buffer with push/pop/clear and head output. fifo_rd_ctrl holds the strobe/inflight/drop logic.

Test Plan:
- Reset then idle: fifo_empty_i=1, ready_i=1 for 10 cycles -> fifo_rd_o=0, valid_o=0, data_o=0 throughout.
- Single pop: FIFO preloaded with 8'hA5, ready_i=1 -> fifo_rd_o=1 at cycle t, capture at t+1, valid_o=1 and data_o=8'hA5 at t+2, valid_o=0 at t+3.
- Streaming: FIFO holds 8'h01..8'h08, ready_i=1 -> after 2-cycle fill, data_o=01..08 on 8 consecutive cycles, no bubbles, fifo_rd_o high for 8 consecutive cycles.
- Backpressure: stream 8'h10..8'h14, ready_i=0 from the 3rd cycle for 5 cycles -> occupancy saturates at 2, fifo_rd_o=0, data_o holds 8'h10; on release, output is 10,11,12,13,14 in order with none lost or duplicated.
- Flush with in-flight read: occupancy 1 (8'h20), strobe issued for 8'h21, flush_i=1 that cycle -> next cycle valid_o=0, returning 8'h21 discarded, next read delivers 8'h22.
- Mid-stream reset: reset_i=1 for 1 cycle while occupancy=2 and inflight=1 -> valid_o=0, data_o=0, fifo_rd_o=0 during reset; with FIFO_RD_STATS_EN, pop_count_o=0 after reset.
